data_mem_responder: RTL and testbench

- Data-memory responder at the far end of the pipeline's load/store interface.
- Accepts read/write requests from the memory stage: enables, byte address, store data and FUNC3 width code.
- Stalls the pipeline with MEM_BUSYWAIT for a fixed access latency, then completes the access.
- Returns width-adjusted, sign/zero-extended load data; signals misaligned accesses.

---
 rtl/data_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency byte-addressable data memory behind the load/store port
// Requests stall the pipeline for LATENCY cycles; loads return width/sign-adjusted data.
module data_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MEM_READ_EN,
   input  logic        MEM_WRITE_EN,
   input  logic [31:0] MEM_ADDR,
   input  logic [31:0] MEM_WRITE_DATA,
   input  logic [2:0]  FUNC3,
   output logic        MEM_BUSYWAIT,
   output logic [31:0] MEM_READ_DATA,
   output logic        MISALIGNED
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [31:0]           data_q;
   logic [2:0]            func3_q;
   logic                  wr_q, rd_q;
   logic [31:0]           mem [DEPTH];

   logic                  req, access, latch;
   logic [ADDR_WIDTH+1:0] acc_addr;
   logic [31:0]           acc_data;
   logic [2:0]            acc_f3;
   logic                  acc_wr, acc_rd;
   logic                  is_half, is_word, misaligned;
   logic [3:0]            be;
   logic [31:0]           wlanes, rword, load_data;
   logic [7:0]            rbyte;
   logic [15:0]           rhalf;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^MEM_ADDR[31:ADDR_WIDTH+2];
   assign req = MEM_READ_EN | MEM_WRITE_EN;

   // With LATENCY=1 the access completes on the request edge, so it uses the live inputs.
   assign acc_addr = (state == IDLE) ? MEM_ADDR[ADDR_WIDTH+1:0] : addr_q;
   assign acc_data = (state == IDLE) ? MEM_WRITE_DATA : data_q;
   assign acc_f3   = (state == IDLE) ? FUNC3 : func3_q;
   assign acc_wr   = (state == IDLE) ? MEM_WRITE_EN : wr_q;
   assign acc_rd   = (state == IDLE) ? MEM_READ_EN : rd_q;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      access       = 1'b0;
      latch        = 1'b0;
      MEM_BUSYWAIT = 1'b0;
      case (state)
         IDLE: begin
            MEM_BUSYWAIT = req;
            if (req) begin
               latch = 1'b1;
               if (LATENCY == 1) begin
                  access    = 1'b1;
                  state_nxt = DONE;
               end else begin
                  cnt_nxt   = CNT_INIT;
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            MEM_BUSYWAIT = 1'b1;
            if (!req) begin
               state_nxt = IDLE;
            end else if (cnt == 4'd0) begin
               access    = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      MEM_BUSYWAIT = MEM_BUSYWAIT & RESET;
   end

   // Reserved store codes are never "halfword", so they cannot raise a misalignment.
   always_comb begin
      is_half    = acc_wr ? (acc_f3 == 3'b001) : (acc_f3[1:0] == 2'b01);
      is_word    = (acc_f3 == 3'b010);
      misaligned = (is_half & acc_addr[0]) | (is_word & (acc_addr[1:0] != 2'b00));
   end

   always_comb begin
      be     = 4'b0000;
      wlanes = acc_data;
      case (acc_f3)
         3'b000: begin
            be[acc_addr[1:0]] = 1'b1;
            wlanes = {4{acc_data[7:0]}};
         end
         3'b001: begin
            be     = acc_addr[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{acc_data[15:0]}};
         end
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_comb begin
      rword = mem[acc_addr[ADDR_WIDTH+1:2]];
      case (acc_addr[1:0])
         2'd0:    rbyte = rword[7:0];
         2'd1:    rbyte = rword[15:8];
         2'd2:    rbyte = rword[23:16];
         default: rbyte = rword[31:24];
      endcase
      rhalf = acc_addr[1] ? rword[31:16] : rword[15:0];
      case (acc_f3)
         3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
         3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
         3'b010:  load_data = rword;
         3'b100:  load_data = {24'd0, rbyte};
         3'b101:  load_data = {16'd0, rhalf};
         default: load_data = 32'd0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         MEM_READ_DATA <= 32'd0;
         MISALIGNED    <= 1'b0;
         addr_q        <= '0;
         data_q        <= 32'd0;
         func3_q       <= 3'd0;
         wr_q          <= 1'b0;
         rd_q          <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         MISALIGNED <= access & misaligned;
         if (latch) begin
            addr_q  <= MEM_ADDR[ADDR_WIDTH+1:0];
            data_q  <= MEM_WRITE_DATA;
            func3_q <= FUNC3;
            wr_q    <= MEM_WRITE_EN;
            rd_q    <= MEM_READ_EN;
         end
         if (access) begin
            if (misaligned) begin
               MEM_READ_DATA <= 32'd0;
            end else if (acc_wr) begin
               if (acc_rd) MEM_READ_DATA <= 32'd0;
            end else begin
               MEM_READ_DATA <= load_data;
            end
         end
      end
   end

   // Storage has no reset; gating on RESET keeps a store from landing while held in reset.
   always_ff @(posedge CLK) begin
      if (RESET && access && acc_wr && !misaligned) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[acc_addr[ADDR_WIDTH+1:2]][8*b +: 8] <= wlanes[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench for data_mem_responder with a transaction-level model
module tb_data_mem_responder;

   localparam int AW    = 10;
   localparam int LAT   = 4;
   localparam int DEPTH = 1 << AW;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        rd_en = 1'b0, wr_en = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [2:0]  func3 = 3'd0;
   logic        MEM_BUSYWAIT;
   logic [31:0] MEM_READ_DATA;
   logic        MISALIGNED;

   logic        chk_en = 1'b0;
   logic        exp_busy = 1'b0, exp_mis = 1'b0;
   logic [31:0] exp_rdata = 32'd0;
   logic [31:0] mmem [int];
   int          n_cmp = 0, n_bad = 0;
   int          busy_seen;
   logic        mis_seen;

   data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
      .CLK(CLK), .RESET(RESET),
      .MEM_READ_EN(rd_en), .MEM_WRITE_EN(wr_en),
      .MEM_ADDR(addr), .MEM_WRITE_DATA(wdata), .FUNC3(func3),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READ_DATA(MEM_READ_DATA), .MISALIGNED(MISALIGNED)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (chk_en) begin
         n_cmp++;
         if (MEM_BUSYWAIT !== exp_busy) begin
            n_bad++;
            $display("FAIL busywait t=%0t got %b expected %b", $time, MEM_BUSYWAIT, exp_busy);
         end
         n_cmp++;
         if (MEM_READ_DATA !== exp_rdata) begin
            n_bad++;
            $display("FAIL read_data t=%0t got %h expected %h", $time, MEM_READ_DATA, exp_rdata);
         end
         n_cmp++;
         if (MISALIGNED !== exp_mis) begin
            n_bad++;
            $display("FAIL misaligned t=%0t got %b expected %b", $time, MISALIGNED, exp_mis);
         end
      end
   end

   task automatic check_lit(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t got %h expected %h", nm, $time, got, want);
      end
   endtask

   // Whole-access effect computed from access size and byte offset.
   task automatic model_access(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] f3, output bit mis);
      int          size, off, widx;
      logic [31:0] w, mask, val;
      off  = int'(a[1:0]);
      widx = int'((a >> 2) & 32'(DEPTH - 1));
      if (wr) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      else    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 :
                     (f3 == 3'd2) ? 4 : 0;
      mis = (size == 2 && (off % 2) != 0) || (size == 4 && off != 0);
      w   = mmem.exists(widx) ? mmem[widx] : 32'd0;
      if (mis) begin
         exp_rdata = 32'd0;
      end else if (wr) begin
         for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = d[8*i +: 8];
         if (size > 0) mmem[widx] = w;
         if (rd) exp_rdata = 32'd0;
      end else if (size == 0) begin
         exp_rdata = 32'd0;
      end else begin
         val = w >> (8 * off);
         if (size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            val  = val & mask;
            if (f3[2] == 1'b0 && val[8*size-1]) val = val | ~mask;
         end
         exp_rdata = val;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         exp_busy = 1'b0;
         exp_mis  = 1'b0;
         @(posedge CLK); #1;
      end
   endtask

   task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input int abort_at, input bit scramble);
      bit mis;
      rd_en = rd; wr_en = wr; addr = a; wdata = d; func3 = f3;
      busy_seen = 0;
      mis_seen  = 1'b0;
      for (int c = 0; c <= LAT; c++) begin
         if (scramble && c > 0 && c < LAT) begin
            case ($urandom_range(0, 2))
               0:       begin rd_en = 1'b1; wr_en = 1'b0; end
               1:       begin rd_en = 1'b0; wr_en = 1'b1; end
               default: begin rd_en = 1'b1; wr_en = 1'b1; end
            endcase
            addr  = $urandom();
            wdata = $urandom();
            func3 = 3'($urandom_range(0, 7));
         end
         if (abort_at > 0 && c == abort_at) begin
            rd_en = 1'b0; wr_en = 1'b0;
            exp_busy = 1'b1;
            exp_mis  = 1'b0;
            @(negedge CLK);
            if (MEM_BUSYWAIT) busy_seen++;
            @(posedge CLK); #1;
            exp_busy = 1'b0;
            return;
         end
         exp_busy = (c < LAT);
         exp_mis  = 1'b0;
         if (c == LAT) begin
            model_access(rd, wr, a, d, f3, mis);
            exp_mis = mis;
         end
         @(negedge CLK);
         if (MEM_BUSYWAIT) busy_seen++;
         if (c == LAT) mis_seen = MISALIGNED;
         @(posedge CLK); #1;
      end
      rd_en = 1'b0; wr_en = 1'b0;
      exp_busy = 1'b0;
      exp_mis  = 1'b0;
   endtask

   initial begin
      int          r, ab;
      bit          rd, wr;
      logic [31:0] a;

      #1 RESET = 1'b0;
      #2;
      check_lit("reset_busywait", {31'd0, MEM_BUSYWAIT}, 32'd0);
      check_lit("reset_read_data", MEM_READ_DATA, 32'd0);
      check_lit("reset_misaligned", {31'd0, MISALIGNED}, 32'd0);
      @(posedge CLK); #1;
      RESET  = 1'b1;
      chk_en = 1'b1;
      idle(5);

      for (int i = 0; i < 64; i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom(), 3'd2, 0, 1'b0);

      txn(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 3'd2, 0, 1'b0);
      check_lit("sw_busy_cycles", 32'(busy_seen), 32'd4);
      idle(1);
      txn(1'b1, 1'b0, 32'h40, 32'h0, 3'd2, 0, 1'b0);
      check_lit("lw_0x40", MEM_READ_DATA, 32'hDEADBEEF);

      txn(1'b0, 1'b1, 32'h10, 32'h0, 3'd2, 0, 1'b0);
      txn(1'b0, 1'b1, 32'h11, 32'h12345680, 3'd0, 0, 1'b0);
      txn(1'b1, 1'b0, 32'h11, 32'h0, 3'd0, 0, 1'b0);
      check_lit("lb_0x11", MEM_READ_DATA, 32'hFFFFFF80);
      txn(1'b1, 1'b0, 32'h11, 32'h0, 3'd4, 0, 1'b0);
      check_lit("lbu_0x11", MEM_READ_DATA, 32'h00000080);
      txn(1'b0, 1'b1, 32'h12, 32'hFFFFA5A5, 3'd1, 0, 1'b0);
      txn(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, 0, 1'b0);
      check_lit("lw_0x10_merge", MEM_READ_DATA, 32'hA5A58000);

      txn(1'b1, 1'b0, 32'h41, 32'h0, 3'd2, 0, 1'b0);
      check_lit("lw_0x41_mis", {31'd0, mis_seen}, 32'd1);
      check_lit("lw_0x41_data", MEM_READ_DATA, 32'd0);
      txn(1'b0, 1'b1, 32'h43, 32'h1111, 3'd1, 0, 1'b0);
      check_lit("sh_0x43_mis", {31'd0, mis_seen}, 32'd1);
      txn(1'b1, 1'b0, 32'h40, 32'h0, 3'd2, 0, 1'b0);
      check_lit("lw_0x40_after_mis", MEM_READ_DATA, 32'hDEADBEEF);

      txn(1'b0, 1'b1, 32'h80, 32'h0BADF00D, 3'd2, 0, 1'b0);
      txn(1'b0, 1'b1, 32'h80, 32'h12345678, 3'd2, 2, 1'b0);
      idle(2);
      txn(1'b1, 1'b0, 32'h80, 32'h0, 3'd2, 0, 1'b0);
      check_lit("lw_0x80_after_abort", MEM_READ_DATA, 32'h0BADF00D);

      rd_en = 1'b0; wr_en = 1'b1; addr = 32'h80; wdata = 32'hCAFEF00D; func3 = 3'd2;
      exp_busy = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK); #2;
      chk_en = 1'b0;
      RESET  = 1'b0;
      #1;
      check_lit("async_rst_busywait", {31'd0, MEM_BUSYWAIT}, 32'd0);
      check_lit("async_rst_read_data", MEM_READ_DATA, 32'd0);
      @(posedge CLK); #1;
      wr_en     = 1'b0;
      RESET     = 1'b1;
      exp_busy  = 1'b0;
      exp_mis   = 1'b0;
      exp_rdata = 32'd0;
      chk_en    = 1'b1;
      idle(1);
      txn(1'b1, 1'b0, 32'h80, 32'h0, 3'd2, 0, 1'b0);
      check_lit("lw_0x80_after_reset", MEM_READ_DATA, 32'h0BADF00D);

      for (int t = 0; t < 400; t++) begin
         r = $urandom_range(0, 9);
         rd = (r < 4) || (r >= 8);
         wr = (r >= 4);
         a  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2) |
              32'($urandom_range(0, 3));
         ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, LAT - 1) : 0;
         txn(rd, wr, a, $urandom(), 3'($urandom_range(0, 7)), ab, 1'b1);
         idle($urandom_range(0, 2));
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
